// File: rtl/time_display_scanner_pkg.sv
// Shared constants for the HH:MM:SS multiplexed display: segment patterns,
// slot indices and per-field legal limits.
package time_display_scanner_pkg;

  localparam int NUM_DIGITS = 6;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = segment lit
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // Digit slot order, least significant digit scanned first
  localparam logic [2:0] SLOT_SEC_ONES = 3'd0;
  localparam logic [2:0] SLOT_SEC_TENS = 3'd1;
  localparam logic [2:0] SLOT_MIN_ONES = 3'd2;
  localparam logic [2:0] SLOT_MIN_TENS = 3'd3;
  localparam logic [2:0] SLOT_HR_ONES  = 3'd4;
  localparam logic [2:0] SLOT_HR_TENS  = 3'd5;

  // Largest legal value of each time field
  localparam logic [5:0] LIMIT_SEC  = 6'd59;
  localparam logic [5:0] LIMIT_MIN  = 6'd59;
  localparam logic [5:0] LIMIT_HOUR = 6'd23;

  // BCD digit to active-high segment pattern; non-decimal codes go dark
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/time_display_scanner_bin_to_bcd60.sv
// Combinational split of a 6-bit time field into two BCD digits, flagging
// values above the field's legal maximum.
module bin_to_bcd60 (
  input  logic [5:0] value,
  input  logic [5:0] limit,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       valid
);

  // Divide by ten; the largest 6-bit input (63) still yields a 1-digit quotient
  always_comb begin
    tens  = 4'(value / 6'd10);
    ones  = 4'(value % 6'd10);
    valid = (value <= limit);
  end

endmodule

// File: rtl/time_display_scanner.sv
// Six-digit HH:MM:SS scanner. Snapshots the clock counters once per scan
// frame, converts them to BCD and time-multiplexes the 7-segment digits,
// blinking the colon points whenever the snapshot second changes.
module time_display_scanner
  import time_display_scanner_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            second,
  input  logic [5:0]            min,
  input  logic [5:0]            hour,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int              PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [2:0]    slot;
  logic          first_edge;
  logic [5:0]    snap_sec;
  logic [5:0]    snap_min;
  logic [5:0]    snap_hour;
  logic          colon;

  logic          slot_last;
  logic          frame_wrap;
  logic          snap_load;

  logic [3:0]    sec_tens, sec_ones, min_tens, min_ones, hr_tens, hr_ones;
  logic          sec_ok, min_ok, hr_ok;

  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_next;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;

  assign slot_last  = (presc == PRESC_LAST);
  assign frame_wrap = slot_last && (slot == SLOT_HR_TENS);
  assign snap_load  = frame_wrap || first_edge;

  // ---- Stage 0: scan timing (prescaler and slot index) ----
  // Each slot dwells exactly SCAN_DIV cycles; slot 5 wraps back to slot 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      slot  <= SLOT_SEC_ONES;
    end else if (slot_last) begin
      presc <= '0;
      slot  <= (slot == SLOT_HR_TENS) ? SLOT_SEC_ONES : slot + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Frame snapshot, colon blink and frame pulse; also loads on the first edge after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_edge <= 1'b1;
      snap_sec   <= '0;
      snap_min   <= '0;
      snap_hour  <= '0;
      colon      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      first_edge <= 1'b0;
      frame_done <= frame_wrap;
      if (snap_load) begin
        snap_sec  <= second;
        snap_min  <= min;
        snap_hour <= hour;
        if (second != snap_sec)
          colon <= ~colon;
      end
    end
  end

  // ---- Stage 1: BCD conversion of the snapshot and digit selection ----
  bin_to_bcd60 u_sec (
    .value (snap_sec),
    .limit (LIMIT_SEC),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .valid (sec_ok)
  );

  bin_to_bcd60 u_min (
    .value (snap_min),
    .limit (LIMIT_MIN),
    .tens  (min_tens),
    .ones  (min_ones),
    .valid (min_ok)
  );

  bin_to_bcd60 u_hour (
    .value (snap_hour),
    .limit (LIMIT_HOUR),
    .tens  (hr_tens),
    .ones  (hr_ones),
    .valid (hr_ok)
  );

  // Pick the current slot's digit; an out-of-range field shows dashes on both digits
  always_comb begin
    seg_next = SEG_OFF;
    case (slot)
      SLOT_SEC_ONES: seg_next = sec_ok ? seg_encode(sec_ones) : SEG_DASH;
      SLOT_SEC_TENS: seg_next = sec_ok ? seg_encode(sec_tens) : SEG_DASH;
      SLOT_MIN_ONES: seg_next = min_ok ? seg_encode(min_ones) : SEG_DASH;
      SLOT_MIN_TENS: seg_next = min_ok ? seg_encode(min_tens) : SEG_DASH;
      SLOT_HR_ONES:  seg_next = hr_ok  ? seg_encode(hr_ones)  : SEG_DASH;
      SLOT_HR_TENS:  seg_next = hr_ok  ? seg_encode(hr_tens)  : SEG_DASH;
      default:       seg_next = SEG_OFF;
    endcase
  end

  // Colon points sit on the minute and hour ones digits; the anode stays dark
  // for the first cycle of each slot so the previous digit cannot ghost
  always_comb begin
    dp_next = colon && ((slot == SLOT_MIN_ONES) || (slot == SLOT_HR_ONES));
    an_next = '0;
    if ((presc != '0) && !blank)
      an_next = NUM_DIGITS'(1) << slot;
  end

  // ---- Stage 2: registered pin drive ----
  // Outputs held active-high internally; polarity is applied only at the pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_OFF;
      dp_q  <= 1'b0;
      an_q  <= '0;
    end else begin
      seg_q <= seg_next;
      dp_q  <= dp_next;
      an_q  <= an_next;
    end
  end

  assign seg = ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp  = ACTIVE_LOW ? ~dp_q  : dp_q;
  assign an  = ACTIVE_LOW ? ~an_q  : an_q;

endmodule

// File: tb/tb_time_display_scanner.sv
// Directed bench for time_display_scanner with SCAN_DIV=4: one instance
// with active-high pins, one with active-low pins for polarity checks.
module tb_time_display_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] second, min, hour;
  logic       blank;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_done;

  logic [5:0] second1, min1, hour1;
  logic       blank1;
  logic [6:0] seg1;
  logic       dp1;
  logic [5:0] an1;
  logic       frame_done1;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] DASH = 4'hA;

  typedef struct packed {
    logic [5:0]      s;
    logic [5:0]      m;
    logic [5:0]      h;
    logic            blk;
    logic [5:0][3:0] d;     // {hr tens, hr ones, min tens, min ones, sec tens, sec ones}
    logic            colon;
  } vec_t;

  vec_t vecs [6];

  time_display_scanner #(.SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u0 (
    .clk        (clk),
    .reset      (reset),
    .second     (second),
    .min        (min),
    .hour       (hour),
    .blank      (blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  time_display_scanner #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1)) u1 (
    .clk        (clk),
    .reset      (reset),
    .second     (second1),
    .min        (min1),
    .hour       (hour1),
    .blank      (blank1),
    .seg        (seg1),
    .dp         (dp1),
    .an         (an1),
    .frame_done (frame_done1)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // Advance to the sample just after the next frame_done of u0
  task automatic wait_frame(input string name);
    bit found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_done) begin
        found = 1;
        break;
      end
    end
    check({name, " frame_done timeout"}, {15'd0, found}, 16'd1);
  endtask

  // Checks 24 samples after a frame_done sample; last sample lands on the next frame_done
  task automatic check_frame(input logic [5:0][3:0] d, input logic colon,
                             input logic blk, input string name);
    for (int k = 1; k <= 24; k++) begin
      int         sl, pk;
      logic [5:0] ea;
      logic       ed, ef;
      @(negedge clk);
      sl = (k - 1) / 4;
      pk = (k - 1) % 4;
      ea = (pk == 0 || blk) ? 6'd0 : 6'(6'b1 << sl);
      ed = colon && (sl == 2 || sl == 4);
      ef = (k == 24);
      check($sformatf("%s k=%0d {fd,dp,an,seg}", name, k),
            {1'b0, frame_done, dp, an, seg}, {1'b0, ef, ed, ea, exp_seg(d[sl])});
    end
  endtask

  initial begin
    //            s      m      h     blk   digits HH MM SS                                   colon
    vecs[0] = '{6'd57, 6'd60, 6'd24, 1'b0, {DASH, DASH, DASH, DASH, 4'd5, 4'd7}, 1'b0};
    vecs[1] = '{6'd8,  6'd5,  6'd23, 1'b0, {4'd2, 4'd3, 4'd0, 4'd5, 4'd0, 4'd8}, 1'b1};
    vecs[2] = '{6'd59, 6'd59, 6'd0,  1'b0, {4'd0, 4'd0, 4'd5, 4'd9, 4'd5, 4'd9}, 1'b0};
    vecs[3] = '{6'd60, 6'd0,  6'd9,  1'b0, {4'd0, 4'd9, 4'd0, 4'd0, DASH, DASH}, 1'b1};
    vecs[4] = '{6'd60, 6'd0,  6'd9,  1'b1, {4'd0, 4'd9, 4'd0, 4'd0, DASH, DASH}, 1'b1};
    vecs[5] = '{6'd0,  6'd0,  6'd0,  1'b0, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0};

    reset = 1'b0;
    second = 6'd56; min = 6'd34; hour = 6'd12; blank = 1'b0;
    second1 = 6'd0; min1 = 6'd0; hour1 = 6'd0; blank1 = 1'b0;

    repeat (3) @(negedge clk);
    check("reset u0 {fd,dp,an,seg}", {1'b0, frame_done, dp, an, seg}, 16'd0);
    check("reset u1 {fd,dp,an,seg}", {1'b0, frame_done1, dp1, an1, seg1},
          {1'b0, 1'b0, 1'b1, 6'b111111, 7'b1111111});
    reset = 1'b1;

    // Mid-frame second change must not tear the frame being shown
    wait_frame("static");
    second = 6'd57;
    check_frame({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, 1'b1, 1'b0, "hold56");
    check_frame({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7}, 1'b0, 1'b0, "show57");

    for (int i = 0; i < 6; i++) begin
      second = vecs[i].s;
      min    = vecs[i].m;
      hour   = vecs[i].h;
      blank  = vecs[i].blk;
      wait_frame($sformatf("vec%0d", i));
      check_frame(vecs[i].d, vecs[i].colon, vecs[i].blk, $sformatf("vec%0d", i));
    end

    // Active-low pins showing 00:00:00
    begin
      bit found = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (frame_done1) begin
          found = 1;
          break;
        end
      end
      check("u1 frame_done timeout", {15'd0, found}, 16'd1);
      @(negedge clk);
      check("u1 slot0 first cycle {dp,an,seg}", {2'b0, dp1, an1, seg1},
            {2'b0, 1'b1, 6'b111111, 7'b1000000});
      @(negedge clk);
      check("u1 slot0 active {dp,an,seg}", {2'b0, dp1, an1, seg1},
            {2'b0, 1'b1, 6'b111110, 7'b1000000});
    end

    // Asynchronous reset between clock edges
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset u0 {fd,dp,an,seg}", {1'b0, frame_done, dp, an, seg}, 16'd0);
    check("midreset u1 {dp,an,seg}", {2'b0, dp1, an1, seg1},
          {2'b0, 1'b1, 6'b111111, 7'b1111111});
    @(negedge clk);
    reset = 1'b1;
    wait_frame("postreset");
    check_frame({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, 1'b0, "postreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
